// File: rtl/riscv_pkg.sv
// Shared core-wide constants for the fetch front end.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
  localparam int PC_STEP = 4;

endpackage

// File: rtl/inst_prefetch_queue_if.sv
// Bundle of the instruction-memory, redirect and decode-side signals of the prefetch queue.
interface inst_prefetch_queue_if
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int DEPTH = 4
) ();

  logic                     imem_req;
  logic [XLEN-1:0]          imem_addr;
  logic [XLEN-1:0]          imem_rdata;
  logic                     redirect_valid;
  logic [XLEN-1:0]          redirect_pc;
  logic                     id_valid;
  logic [XLEN-1:0]          id_inst;
  logic [XLEN-1:0]          id_pc;
  logic                     id_ready;
  logic [$clog2(DEPTH):0]   occupancy;

  // master is the prefetch queue itself; slave is memory/execute/decode around it
  modport master (
    output imem_req, imem_addr, id_valid, id_inst, id_pc, occupancy,
    input  imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_inst, id_pc, occupancy,
    output imem_rdata, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with flush; head data reads as zero when empty.
module sync_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && (count_q != CW'(DEPTH));

  // flush wins over any push or pop presented in the same cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign valid = (count_q != '0);
  assign head  = valid ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/inst_prefetch_queue.sv
// Fetch front end: PC generation, credit-limited imem reads and a prefetch FIFO toward decode.
module inst_prefetch_queue
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  inst_prefetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;

  logic [CW-1:0]     count;
  logic [CW:0]       credit_used;
  logic              issue_ok;
  logic              push, pop;
  logic              fifo_valid;
  logic [2*XLEN-1:0] fifo_head;
  logic [XLEN-1:0]   redirect_target;

  assign redirect_target = bus.redirect_pc & ~XLEN'(3);

  // the in-flight response holds a slot; a same-cycle pop is deliberately not credited
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, req_q};
  assign issue_ok    = !bus.redirect_valid && (credit_used < (CW+1)'(DEPTH));

  assign bus.imem_req  = issue_ok && !sys_rst;
  assign bus.imem_addr = fetch_pc_q;

  assign push = req_q && !bus.redirect_valid;
  assign pop  = fifo_valid && bus.id_ready && !bus.redirect_valid;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    req_d      = issue_ok;
    if (bus.redirect_valid) begin
      fetch_pc_d = redirect_target;
    end else if (issue_ok) begin
      fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
      pc_d       = fetch_pc_q;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      fetch_pc_q <= RESET_PC;
      pc_q       <= '0;
      req_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   ({bus.imem_rdata, pc_q}),
    .head  (fifo_head),
    .valid (fifo_valid),
    .count (count)
  );

  assign bus.id_valid  = fifo_valid;
  assign bus.id_inst   = fifo_head[2*XLEN-1:XLEN];
  assign bus.id_pc     = fifo_head[XLEN-1:0];
  assign bus.occupancy = count;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue: cycle tables, reset corner case and a random scoreboard run.
module tb_inst_prefetch_queue;
  import riscv_pkg::*;

  localparam int DEPTH = 4;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  always #5 sys_clk = ~sys_clk;

  inst_prefetch_queue_if #(.XLEN(32), .DEPTH(DEPTH)) bus ();

  inst_prefetch_queue #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  // instruction memory: word at byte address a holds a>>2, one cycle read latency
  always @(posedge sys_clk) begin
    if (bus.imem_req) bus.imem_rdata <= bus.imem_addr >> 2;
  end

  typedef struct packed {
    logic        do_reset;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [2:0]  exp_occ;
  } vec_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  vec_t tbl[$];
  exp_t expq[$];

  function automatic vec_t mk(logic rs, logic rdy, logic rv, logic [31:0] rpc,
                              logic req, logic [31:0] addr, logic v,
                              logic [31:0] pc, logic [31:0] inst, logic [2:0] occ);
    vec_t t;
    t.do_reset = rs;  t.ready = rdy; t.redir = rv; t.rpc = rpc;
    t.exp_req = req;  t.exp_addr = addr; t.exp_valid = v;
    t.exp_pc = pc;    t.exp_inst = inst; t.exp_occ = occ;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic doReset();
    sys_rst = 1'b1;
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.do_reset) doReset();
    else tick();
    bus.id_ready       = v.ready;
    bus.redirect_valid = v.redir;
    bus.redirect_pc    = v.rpc;
  endtask

  // scoreboard: every issued read becomes an expectation, flushed on redirect or reset
  always @(negedge sys_clk) begin
    exp_t e;
    if (sys_rst || bus.redirect_valid) begin
      expq.delete();
    end else begin
      if (bus.id_valid && bus.id_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_unexpected: got pc %h expected no delivery", bus.id_pc);
        end else begin
          e = expq.pop_front();
          checkOutput("sb_pc", bus.id_pc, e.pc);
          checkOutput("sb_inst", bus.id_inst, e.inst);
        end
      end
      if (bus.imem_req) expq.push_back({bus.imem_addr >> 2, bus.imem_addr});
    end
  end

  initial begin
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // streaming with decode always ready
    tbl.push_back(mk(1,1,0,0, 1,32'h00,0,32'h00,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h04,0,32'h00,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h08,1,32'h00,0,1));
    tbl.push_back(mk(0,1,0,0, 1,32'h0C,1,32'h04,1,1));
    tbl.push_back(mk(0,1,0,0, 1,32'h10,1,32'h08,2,1));
    tbl.push_back(mk(0,1,0,0, 1,32'h14,1,32'h0C,3,1));
    // decode stalled until the queue fills, then released
    tbl.push_back(mk(1,0,0,0, 1,32'h00,0,32'h00,0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h04,0,32'h00,0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h08,1,32'h00,0,1));
    tbl.push_back(mk(0,0,0,0, 1,32'h0C,1,32'h00,0,2));
    tbl.push_back(mk(0,0,0,0, 0,32'h10,1,32'h00,0,3));
    tbl.push_back(mk(0,0,0,0, 0,32'h10,1,32'h00,0,4));
    tbl.push_back(mk(0,0,0,0, 0,32'h10,1,32'h00,0,4));
    tbl.push_back(mk(0,1,0,0, 0,32'h10,1,32'h00,0,4));
    tbl.push_back(mk(0,1,0,0, 1,32'h10,1,32'h04,1,3));
    tbl.push_back(mk(0,1,0,0, 1,32'h14,1,32'h08,2,2));
    tbl.push_back(mk(0,1,0,0, 1,32'h18,1,32'h0C,3,2));
    tbl.push_back(mk(0,1,0,0, 1,32'h1C,1,32'h10,4,2));
    // redirect with 3 queued + 1 in flight, unaligned redirect, back-to-back redirects
    tbl.push_back(mk(1,0,0,0,      1,32'h00,0,32'h00,0,0));
    tbl.push_back(mk(0,0,0,0,      1,32'h04,0,32'h00,0,0));
    tbl.push_back(mk(0,0,0,0,      1,32'h08,1,32'h00,0,1));
    tbl.push_back(mk(0,0,0,0,      1,32'h0C,1,32'h00,0,2));
    tbl.push_back(mk(0,0,1,32'h40, 0,32'h10,1,32'h00,0,3));
    tbl.push_back(mk(0,1,0,0,      1,32'h40,0,32'h00,0,0));
    tbl.push_back(mk(0,1,0,0,      1,32'h44,0,32'h00,0,0));
    tbl.push_back(mk(0,1,0,0,      1,32'h48,1,32'h40,32'h10,1));
    tbl.push_back(mk(0,1,1,32'h43, 0,32'h4C,1,32'h44,32'h11,1));
    tbl.push_back(mk(0,1,0,0,      1,32'h40,0,32'h00,0,0));
    tbl.push_back(mk(0,1,0,0,      1,32'h44,0,32'h00,0,0));
    tbl.push_back(mk(0,1,0,0,      1,32'h48,1,32'h40,32'h10,1));
    tbl.push_back(mk(0,1,1,32'h100,0,32'h4C,1,32'h44,32'h11,1));
    tbl.push_back(mk(0,1,1,32'h200,0,32'h100,0,32'h00,0,0));
    tbl.push_back(mk(0,1,0,0,      1,32'h200,0,32'h00,0,0));
    tbl.push_back(mk(0,1,0,0,      1,32'h204,0,32'h00,0,0));
    tbl.push_back(mk(0,1,0,0,      1,32'h208,1,32'h200,32'h80,1));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      @(negedge sys_clk);
      checkOutput($sformatf("row%0d_imem_req", i),  {31'b0, bus.imem_req},  {31'b0, tbl[i].exp_req});
      checkOutput($sformatf("row%0d_imem_addr", i), bus.imem_addr,          tbl[i].exp_addr);
      checkOutput($sformatf("row%0d_id_valid", i),  {31'b0, bus.id_valid},  {31'b0, tbl[i].exp_valid});
      checkOutput($sformatf("row%0d_id_pc", i),     bus.id_pc,              tbl[i].exp_pc);
      checkOutput($sformatf("row%0d_id_inst", i),   bus.id_inst,            tbl[i].exp_inst);
      checkOutput($sformatf("row%0d_occupancy", i), {29'b0, bus.occupancy}, {29'b0, tbl[i].exp_occ});
    end

    // asynchronous reset between edges with three entries queued and a request pending
    doReset();
    for (int c = 1; c <= 8; c++) begin
      tick();
      bus.id_ready = (c == 7);
    end
    #2;
    checkOutput("prerst_occupancy", {29'b0, bus.occupancy}, 32'd3);
    checkOutput("prerst_imem_req",  {31'b0, bus.imem_req},  32'd1);
    checkOutput("prerst_id_pc",     bus.id_pc,              32'h04);
    #2;
    sys_rst = 1'b1;
    #1;
    checkOutput("rst_id_valid",  {31'b0, bus.id_valid},  32'd0);
    checkOutput("rst_imem_req",  {31'b0, bus.imem_req},  32'd0);
    checkOutput("rst_occupancy", {29'b0, bus.occupancy}, 32'd0);
    checkOutput("rst_id_pc",     bus.id_pc,              32'd0);
    checkOutput("rst_id_inst",   bus.id_inst,            32'd0);
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    bus.id_ready = 1'b1;
    #1;
    checkOutput("postrst_imem_req",  {31'b0, bus.imem_req}, 32'd1);
    checkOutput("postrst_imem_addr", bus.imem_addr,         32'h0);

    // random backpressure and occasional redirects, checked by the scoreboard
    for (int c = 0; c < 400; c++) begin
      tick();
      bus.id_ready       = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      bus.redirect_pc    = 32'($urandom_range(0, 4095));
      @(negedge sys_clk);
      if (bus.occupancy > 3'(DEPTH)) begin
        checks++;
        errors++;
        $display("[TB] FAIL occupancy_bound: got %0d expected at most %0d", bus.occupancy, DEPTH);
      end
    end
    tick();
    bus.redirect_valid = 1'b0;
    bus.id_ready       = 1'b1;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
